// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: control unit <-> datapath/memory signal bundle.
// illegal_op exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                alu_zero;
  logic                alu_carry;
  logic                mem_req;
  logic                mem_we;
  logic                ir_load;
  logic                pc_inc;
  logic [ALU_OP_W-1:0] alu_op;
  logic                use_immediate;
  logic                write_enable;
  logic                jmp_enable;
  logic                zero_flag;
  logic                carry_flag;
  logic                halted;
  logic [2:0]          state;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic                illegal_op;
`endif
  modport master (
`ifdef CTRL_ILLEGAL_TRAP_EN
    output illegal_op,
`endif
    input  opcode, mem_ready, alu_zero, alu_carry,
    output mem_req, mem_we, ir_load, pc_inc, alu_op, use_immediate,
    output write_enable, jmp_enable, zero_flag, carry_flag, halted, state
  );
  modport slave (
`ifdef CTRL_ILLEGAL_TRAP_EN
    input  illegal_op,
`endif
    output opcode, mem_ready, alu_zero, alu_carry,
    input  mem_req, mem_we, ir_load, pc_inc, alu_op, use_immediate,
    input  write_enable, jmp_enable, zero_flag, carry_flag, halted, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: fetch/decode/execute sequencer with memory handshake and zero/carry flags.
// Define CTRL_ILLEGAL_TRAP_EN to halt on illegal opcodes and raise a sticky illegal_op.
module multicycle_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int ALU_OP_W = 4
) (
  input logic clk,
  input logic rst_n,
  multicycle_control_unit_if.master bus
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5;
  logic [2:0] st, st_n;
  logic [3:0] op, op_d, aop;
  logic [OPCODE_W+3:0] opx;
  logic bad, trap, alu, imm, wr;
  logic zf, cf;
  assign opx = {4'b0, bus.opcode};
  assign bad = (|opx[OPCODE_W+3:4]) || opx[3:0] == 4'hb;
  // illegal opcodes are folded to NOP so they never reach the execute decode
  assign op_d = bad ? 4'h0 : opx[3:0];
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic ill;
  assign trap = bad;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ill <= 1'b0;
    else if (st == DECODE && bad) ill <= 1'b1;
  assign bus.illegal_op = ill;
`else
  assign trap = 1'b0;
`endif
  always_comb begin
    st_n = st == FETCH  ? (bus.mem_ready ? DECODE : FETCH)
         : st == DECODE ? (op_d[3:1] == 3'b100 ? MEM : (op_d == 4'hf || trap) ? HALT : EXEC)
         : st == MEM    ? (bus.mem_ready ? (op == 4'h8 ? WB : FETCH) : MEM)
         : st == HALT   ? HALT
         : FETCH;
  end
  assign alu = op >= 4'h1 && op <= 4'h7;
  assign imm = op == 4'h6 || op == 4'h7 || op == 4'ha;
  assign wr  = alu || op == 4'ha;
  assign aop = op == 4'h6 ? 4'h1 : op == 4'h7 ? 4'h2 : op <= 4'h5 ? op : 4'h0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= FETCH;
      op <= 4'h0;
      zf <= 1'b0;
      cf <= 1'b0;
    end else begin
      st <= st_n;
      if (st == DECODE) op <= op_d;
      if (st == EXEC && alu) begin
        zf <= bus.alu_zero;
        cf <= bus.alu_carry;
      end
    end
  assign bus.mem_req       = st == FETCH || st == MEM;
  assign bus.mem_we        = st == MEM && op == 4'h9;
  assign bus.ir_load       = st == FETCH && bus.mem_ready;
  assign bus.pc_inc        = st == FETCH && bus.mem_ready;
  assign bus.alu_op        = ALU_OP_W'(st == EXEC ? aop : st == MEM ? 4'h1 : 4'h0);
  assign bus.use_immediate = st == MEM || (st == EXEC && imm);
  assign bus.write_enable  = st == WB || (st == EXEC && wr);
  // jumps see the flags from before this instruction; they are only written by ALU ops
  assign bus.jmp_enable    = st == EXEC && ((op == 4'hc && zf) || (op == 4'hd && !zf) || op == 4'he);
  assign bus.zero_flag     = zf;
  assign bus.carry_flag    = cf;
  assign bus.halted        = st == HALT;
  assign bus.state         = st;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized instruction-level checks against a per-instruction model.
module tb_multicycle_control_unit;
  localparam int OW = 6;
  localparam int AW = 5;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic mz = 1'b0, mc = 1'b0, m_ill = 1'b0;
  multicycle_control_unit_if #(.OPCODE_W(OW), .ALU_OP_W(AW)) bus();
  multicycle_control_unit #(.OPCODE_W(OW), .ALU_OP_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic bit is_ill(input logic [OW-1:0] o);
    return (o >> 4) != 0 || o[3:0] == 4'hb;
  endfunction

  // Runs one instruction from the start of FETCH; phases: 0 fetch,1 decode,2 exec,3 mem,4 wb,5 halt.
  task automatic exec_instr(input logic [OW-1:0] opc, input int fw, input int mw,
                            input logic az, input logic ac, input int nhalt);
    int ph[$];
    bit mrq[$];
    logic [3:0] n;
    bit ill;
    logic [AW-1:0] e_aop;
    logic [17:0] got, exp;
    ill = is_ill(opc);
    n = ill ? 4'h0 : opc[3:0];
    for (int i = 0; i <= fw; i++) begin ph.push_back(0); mrq.push_back(i == fw); end
    ph.push_back(1); mrq.push_back(1'($urandom));
    if (n == 4'hf || (TRAP && ill))
      for (int i = 0; i <= nhalt; i++) begin ph.push_back(5); mrq.push_back(1'($urandom)); end
    else if (n == 4'h8 || n == 4'h9) begin
      for (int i = 0; i <= mw; i++) begin ph.push_back(3); mrq.push_back(i == mw); end
      if (n == 4'h8) begin ph.push_back(4); mrq.push_back(1'($urandom)); end
    end else begin
      ph.push_back(2); mrq.push_back(1'($urandom));
    end
    foreach (ph[i]) begin
      bus.opcode    = ph[i] <= 1 ? opc : OW'($urandom);
      bus.mem_ready = mrq[i];
      bus.alu_zero  = ph[i] == 2 ? az : 1'($urandom);
      bus.alu_carry = ph[i] == 2 ? ac : 1'($urandom);
      #1;
      e_aop = ph[i] == 3 ? AW'(1) : ph[i] != 2 ? AW'(0)
            : n <= 4'h5 ? AW'(n) : n == 4'h6 ? AW'(1) : n == 4'h7 ? AW'(2) : AW'(0);
      exp = {ph[i] == 0 || ph[i] == 3,
             ph[i] == 3 && n == 4'h9,
             ph[i] == 0 && mrq[i],
             ph[i] == 0 && mrq[i],
             ph[i] == 3 || (ph[i] == 2 && (n == 4'h6 || n == 4'h7 || n == 4'ha)),
             ph[i] == 4 || (ph[i] == 2 && n inside {[4'h1:4'h7], 4'ha}),
             ph[i] == 2 && ((n == 4'hc && mz) || (n == 4'hd && !mz) || n == 4'he),
             ph[i] == 5, mz, mc, 3'(ph[i]), e_aop};
      got = {bus.mem_req, bus.mem_we, bus.ir_load, bus.pc_inc, bus.use_immediate,
             bus.write_enable, bus.jmp_enable, bus.halted, bus.zero_flag, bus.carry_flag,
             bus.state, bus.alu_op};
      n_chk++;
      if (got !== exp) $display("FAIL instr op=%h cycle %0d: got %h expected %h", opc, i, got, exp);
      else n_pass++;
`ifdef CTRL_ILLEGAL_TRAP_EN
      n_chk++;
      if (bus.illegal_op !== m_ill) $display("FAIL illegal_op op=%h cycle %0d: got %b expected %b", opc, i, bus.illegal_op, m_ill);
      else n_pass++;
`endif
      if (ph[i] == 1 && ill) m_ill = TRAP;
      if (ph[i] == 2 && n >= 4'h1 && n <= 4'h7) begin mz = az; mc = ac; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mz = 1'b0; mc = 1'b0; m_ill = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.opcode = '0; bus.mem_ready = 1'b0; bus.alu_zero = 1'b0; bus.alu_carry = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({bus.state, bus.zero_flag, bus.carry_flag, bus.mem_we, bus.write_enable} !== 7'b0)
      $display("FAIL reset_state: got st=%0d z=%b c=%b we=%b wr=%b expected all 0", bus.state, bus.zero_flag, bus.carry_flag, bus.mem_we, bus.write_enable);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.ir_load !== 1'b0) $display("FAIL reset_release: got req=%b ir=%b expected 1 0", bus.mem_req, bus.ir_load);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_addi();
    exec_instr(6'h06, 0, 0, 1'b1, 1'b0, 0);
    n_chk++;
    if (bus.zero_flag !== 1'b1) $display("FAIL addi_zero: got %b expected 1", bus.zero_flag);
    else n_pass++;
  endtask

  task automatic test_jumps();
    exec_instr(6'h0c, 0, 0, 1'b0, 1'b1, 0);
    exec_instr(6'h0d, 0, 0, 1'b0, 1'b1, 0);
    exec_instr(6'h0e, 1, 0, 1'b0, 1'b0, 0);
    n_chk++;
    if (bus.zero_flag !== 1'b1 || bus.carry_flag !== 1'b0) $display("FAIL jump_flags: got z=%b c=%b expected 1 0", bus.zero_flag, bus.carry_flag);
    else n_pass++;
  endtask

  task automatic test_memory();
    exec_instr(6'h08, 0, 2, 1'b0, 1'b0, 0);
    exec_instr(6'h09, 0, 0, 1'b0, 1'b0, 0);
    exec_instr(6'h09, 1, 3, 1'b0, 1'b0, 0);
    exec_instr(6'h0a, 0, 0, 1'b0, 1'b1, 0);
  endtask

  task automatic test_fetch_stall();
    exec_instr(6'h01, 4, 0, 1'b0, 1'b1, 0);
    exec_instr(6'h00, 2, 0, 1'b1, 1'b1, 0);
  endtask

  task automatic test_random();
    logic [OW-1:0] o;
    for (int k = 0; k < 60; k++) begin
      do o = $urandom_range(0, 3) != 0 ? OW'($urandom_range(0, 15)) : OW'($urandom);
      while (o == 6'h0f || (TRAP && is_ill(o)));
      exec_instr(o, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 1'($urandom), 0);
    end
  endtask

  task automatic test_midreset();
    exec_instr(6'h07, 0, 0, 1'b1, 1'b1, 0);
    bus.opcode = 6'h09; bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    n_chk++;
    if (bus.state !== 3'd3 || bus.mem_we !== 1'b1) $display("FAIL midreset_mem: got st=%0d we=%b expected 3 1", bus.state, bus.mem_we);
    else n_pass++;
    @(negedge clk);
    #3 rst_n = 1'b0;
    mz = 1'b0; mc = 1'b0; m_ill = 1'b0;
    #1;
    n_chk++;
    if ({bus.state, bus.mem_we, bus.zero_flag, bus.carry_flag} !== 6'b0)
      $display("FAIL midreset_async: got st=%0d we=%b z=%b c=%b expected all 0", bus.state, bus.mem_we, bus.zero_flag, bus.carry_flag);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (bus.mem_req !== 1'b1 || bus.state !== 3'd0) $display("FAIL midreset_release: got req=%b st=%0d expected 1 0", bus.mem_req, bus.state);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    exec_instr(6'h0b, 0, 0, 1'b0, 1'b0, 2);
    if (TRAP) do_reset();
    exec_instr(6'h21, 1, 0, 1'b1, 1'b1, 2);
    if (TRAP) do_reset();
    exec_instr(6'h38, 0, 1, 1'b1, 1'b1, 2);
    if (TRAP) do_reset();
  endtask

  task automatic test_halt();
    exec_instr(6'h0f, 1, 0, 1'b0, 1'b0, 20);
  endtask

  initial begin
    test_reset();
    test_addi();
    test_jumps();
    test_memory();
    test_fetch_stall();
    test_random();
    test_midreset();
    test_illegal();
    test_random();
    test_halt();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
